// File: rtl/oam_dma.sv
// oam_dma: CPU-side OAM register decode ($2003/$2004) and $4014 page DMA into sprite memory.
module oam_dma #(
    parameter logic [15:0] DMA_REG     = 16'h4014,
    parameter logic [15:0] OAMADDR_REG = 16'h2003,
    parameter logic [15:0] OAMDATA_REG = 16'h2004
) (
    input  logic        pin_clock,
    input  logic        pin_reset,
    input  logic        pin_ce,
    input  logic [15:0] pin_address,
    input  logic [7:0]  pin_o,
    input  logic        pin_w,
    input  logic [7:0]  pin_i,
    output logic        dma_halt,
    output logic [15:0] dma_address,
    output logic        dma_read,
    output logic [7:0]  oam_address,
    output logic [7:0]  oam_data,
    output logic        oam_we,
    output logic [7:0]  oam_addr_reg
);
    typedef enum logic [2:0] {IDLE, HALT, ALIGN, READ, WRITE} state_t;

    state_t      state_q, state_d;
    logic        parity_q, parity_d;
    logic [7:0]  page_q, page_d;
    logic [7:0]  i_q, i_d;
    logic [7:0]  oamaddr_q, oamaddr_d;
    logic [15:0] dma_address_q, dma_address_d;
    logic        cpu_wr, data_wr, dma_wr;

    assign cpu_wr  = pin_ce && pin_w && state_q == IDLE;
    assign data_wr = cpu_wr && pin_address == OAMDATA_REG;
    assign dma_wr  = pin_ce && state_q == WRITE;

    always_comb begin
        state_d       = state_q;
        parity_d      = parity_q;
        page_d        = page_q;
        i_d           = i_q;
        oamaddr_d     = oamaddr_q;
        dma_address_d = dma_address_q;
        if (pin_ce) begin
            parity_d = ~parity_q;
            case (state_q)
                IDLE: begin
                    if (cpu_wr && pin_address == OAMADDR_REG) oamaddr_d = pin_o;
                    if (data_wr) oamaddr_d = oamaddr_q + 8'd1;
                    if (cpu_wr && pin_address == DMA_REG) begin
                        page_d  = pin_o;
                        i_d     = 8'd0;
                        state_d = HALT;
                    end
                end
                HALT:    state_d = parity_q ? ALIGN : READ;
                ALIGN:   state_d = READ;
                READ:    state_d = WRITE;
                WRITE: begin
                    i_d     = i_q + 8'd1;
                    state_d = (i_q == 8'hFF) ? IDLE : READ;
                end
                default: state_d = IDLE;
            endcase
            // Address is held through WRITE so the registered memory data stays valid.
            if (state_d == READ) dma_address_d = {page_d, i_d};
        end
    end

    always_ff @(posedge pin_clock or posedge pin_reset) begin
        if (pin_reset) begin
            state_q       <= IDLE;
            parity_q      <= 1'b0;
            page_q        <= 8'd0;
            i_q           <= 8'd0;
            oamaddr_q     <= 8'd0;
            dma_address_q <= 16'd0;
        end else begin
            state_q       <= state_d;
            parity_q      <= parity_d;
            page_q        <= page_d;
            i_q           <= i_d;
            oamaddr_q     <= oamaddr_d;
            dma_address_q <= dma_address_d;
        end
    end

    assign dma_halt     = state_q != IDLE;
    assign dma_read     = state_q == READ;
    assign dma_address  = dma_address_q;
    assign oam_addr_reg = oamaddr_q;
    assign oam_we       = !pin_reset && (data_wr || dma_wr);
    assign oam_address  = !oam_we ? 8'd0 : dma_wr ? oamaddr_q + i_q : oamaddr_q;
    assign oam_data     = !oam_we ? 8'd0 : dma_wr ? pin_i : pin_o;
endmodule

// File: tb/tb_oam_dma.sv
// tb_oam_dma: directed bench for oam_dma with a registered memory model and an OAM shadow.
module tb_oam_dma;
    logic        pin_clock = 1'b0;
    logic        pin_reset = 1'b1;
    logic        pin_ce = 1'b0;
    logic [15:0] pin_address = 16'd0;
    logic [7:0]  pin_o = 8'd0;
    logic        pin_w = 1'b0;
    logic [7:0]  pin_i = 8'd0;
    logic        dma_halt, dma_read, oam_we;
    logic [15:0] dma_address;
    logic [7:0]  oam_address, oam_data, oam_addr_reg;

    int n_cmp = 0;
    int n_bad = 0;
    logic par = 1'b0;
    logic [7:0]  oam [256];
    logic [15:0] dlog [600];
    int we_cnt = 0, halt_cnt = 0, dcnt = 0;

    oam_dma dut (
        .pin_clock(pin_clock), .pin_reset(pin_reset), .pin_ce(pin_ce),
        .pin_address(pin_address), .pin_o(pin_o), .pin_w(pin_w), .pin_i(pin_i),
        .dma_halt(dma_halt), .dma_address(dma_address), .dma_read(dma_read),
        .oam_address(oam_address), .oam_data(oam_data), .oam_we(oam_we),
        .oam_addr_reg(oam_addr_reg)
    );

    always #5 pin_clock = ~pin_clock;

    function automatic logic [7:0] mem_f(input logic [15:0] a);
        return (a[15:8] == 8'h02) ? (a[7:0] ^ 8'h5A) : (a[7:0] ^ a[15:8] ^ 8'hC3);
    endfunction

    always @(posedge pin_clock) pin_i <= mem_f(dma_address);

    always @(posedge pin_clock) begin
        if (oam_we) begin
            oam[oam_address] = oam_data;
            we_cnt++;
        end
        if (pin_ce && dma_halt) halt_cnt++;
        if (pin_ce && dma_read && dcnt < 600) begin
            dlog[dcnt] = dma_address;
            dcnt++;
        end
    end

    task automatic tick(input logic [15:0] a, input logic [7:0] d, input logic w);
        @(negedge pin_clock);
        pin_address = a; pin_o = d; pin_w = w; pin_ce = 1'b1;
        @(negedge pin_clock);
        pin_ce = 1'b0; pin_w = 1'b0; pin_address = 16'd0;
        par = ~par;
    endtask

    task automatic clear_oam();
        for (int n = 0; n < 256; n++) oam[n] = 8'hxx;
        we_cnt = 0; halt_cnt = 0; dcnt = 0;
    endtask

    task automatic run_dma(input logic [7:0] page, input logic want_par);
        int k;
        if (par != ~want_par) tick(16'd0, 8'd0, 1'b0);
        clear_oam();
        tick(16'h4014, page, 1'b1);
        n_cmp++;
        if (dma_halt !== 1'b1) begin
            n_bad++; $display("FAIL halt_rise: dma_halt=%b expected 1", dma_halt);
        end
        for (k = 0; k < 1200 && dma_halt; k++) tick(16'd0, 8'd0, 1'b0);
        n_cmp++;
        if (dma_halt !== 1'b0) begin
            n_bad++; $display("FAIL dma_timeout: dma_halt still %b after %0d ce cycles", dma_halt, k);
        end
        n_cmp++;
        if (halt_cnt !== 513 + int'(want_par)) begin
            n_bad++; $display("FAIL dma_length: got %0d ce cycles expected %0d", halt_cnt, 513 + int'(want_par));
        end
        n_cmp++;
        if (we_cnt !== 256) begin
            n_bad++; $display("FAIL dma_writes: got %0d expected 256", we_cnt);
        end
    endtask

    task automatic check_contents(input logic [7:0] page, input logic [7:0] off);
        int errs = 0;
        logic [7:0] exp;
        for (int n = 0; n < 256; n++) begin
            exp = mem_f({page, 8'(n)});
            if (oam[8'(off + n)] !== exp) begin
                if (errs == 0) $display("FAIL oam_contents: oam[%02h]=%02h expected %02h", 8'(off + n), oam[8'(off + n)], exp);
                errs++;
            end
        end
        n_cmp++;
        if (errs != 0) n_bad++;
    endtask

    task automatic test_reset();
        pin_reset = 1'b1;
        repeat (3) @(negedge pin_clock);
        pin_reset = 1'b0;
        par = 1'b0;
        tick(16'h2003, 8'h55, 1'b1);
        n_cmp++;
        if (oam_addr_reg !== 8'h55) begin
            n_bad++; $display("FAIL pre_reset_addr: got %02h expected 55", oam_addr_reg);
        end
        #3 pin_reset = 1'b1;
        #1;
        n_cmp++;
        if ({dma_halt, dma_read, oam_we, dma_address, oam_address, oam_data} !== 35'd0) begin
            n_bad++; $display("FAIL reset_outputs: halt=%b read=%b we=%b da=%04h oa=%02h od=%02h expected all 0",
                              dma_halt, dma_read, oam_we, dma_address, oam_address, oam_data);
        end
        n_cmp++;
        if (oam_addr_reg !== 8'h00) begin
            n_bad++; $display("FAIL reset_oamaddr: got %02h expected 00", oam_addr_reg);
        end
        @(negedge pin_clock);
        pin_reset = 1'b0;
        par = 1'b0;
    endtask

    task automatic test_regs();
        clear_oam();
        tick(16'h2003, 8'h10, 1'b1);
        tick(16'h2004, 8'hAA, 1'b1);
        tick(16'h2004, 8'hBB, 1'b1);
        n_cmp++;
        if (oam[8'h10] !== 8'hAA) begin
            n_bad++; $display("FAIL reg_oam10: got %02h expected AA", oam[8'h10]);
        end
        n_cmp++;
        if (oam[8'h11] !== 8'hBB) begin
            n_bad++; $display("FAIL reg_oam11: got %02h expected BB", oam[8'h11]);
        end
        n_cmp++;
        if (oam_addr_reg !== 8'h12) begin
            n_bad++; $display("FAIL reg_oamaddr: got %02h expected 12", oam_addr_reg);
        end
        @(negedge pin_clock);
        pin_address = 16'h2004; pin_o = 8'h77; pin_w = 1'b1;
        #1;
        n_cmp++;
        if (oam_we !== 1'b0) begin
            n_bad++; $display("FAIL no_ce_we: oam_we=%b expected 0", oam_we);
        end
        @(negedge pin_clock);
        pin_w = 1'b0; pin_address = 16'd0;
        n_cmp++;
        if (oam_addr_reg !== 8'h12 || we_cnt !== 2) begin
            n_bad++; $display("FAIL no_ce_hold: oamaddr=%02h writes=%0d expected 12 and 2", oam_addr_reg, we_cnt);
        end
    endtask

    task automatic test_dma_even();
        tick(16'h2003, 8'h00, 1'b1);
        run_dma(8'h02, 1'b0);
        check_contents(8'h02, 8'h00);
        n_cmp++;
        if (oam_addr_reg !== 8'h00) begin
            n_bad++; $display("FAIL even_oamaddr: got %02h expected 00", oam_addr_reg);
        end
    endtask

    task automatic test_dma_odd();
        int errs = 0;
        run_dma(8'h02, 1'b1);
        check_contents(8'h02, 8'h00);
        for (int k = 0; k < 256; k++)
            if (dlog[k] !== (16'h0200 + 16'(k))) begin
                if (errs == 0) $display("FAIL dma_addr_seq: step %0d got %04h expected %04h", k, dlog[k], 16'h0200 + 16'(k));
                errs++;
            end
        n_cmp++;
        if (errs != 0 || dcnt != 256) begin
            n_bad++; $display("FAIL dma_addr_count: reads=%0d errs=%0d expected 256 and 0", dcnt, errs);
        end
    endtask

    task automatic test_wrap();
        tick(16'h2003, 8'hF0, 1'b1);
        run_dma(8'h03, 1'b0);
        n_cmp++;
        if (oam[8'hF0] !== 8'hC0) begin
            n_bad++; $display("FAIL wrap_first: oam[F0]=%02h expected C0", oam[8'hF0]);
        end
        n_cmp++;
        if (oam[8'h00] !== 8'hD0) begin
            n_bad++; $display("FAIL wrap_0310: oam[00]=%02h expected D0", oam[8'h00]);
        end
        n_cmp++;
        if (oam[8'hEF] !== 8'h3F) begin
            n_bad++; $display("FAIL wrap_last: oam[EF]=%02h expected 3F", oam[8'hEF]);
        end
        check_contents(8'h03, 8'hF0);
        n_cmp++;
        if (oam_addr_reg !== 8'hF0) begin
            n_bad++; $display("FAIL wrap_oamaddr: got %02h expected F0", oam_addr_reg);
        end
    endtask

    task automatic test_reset_mid();
        int k;
        tick(16'h2003, 8'h00, 1'b1);
        clear_oam();
        tick(16'h4014, 8'h02, 1'b1);
        for (k = 0; k < 400 && we_cnt < 100; k++) tick(16'd0, 8'd0, 1'b0);
        n_cmp++;
        if (we_cnt !== 100) begin
            n_bad++; $display("FAIL mid_reach100: writes=%0d expected 100", we_cnt);
        end
        #3 pin_reset = 1'b1;
        #1;
        n_cmp++;
        if (dma_halt !== 1'b0 || dma_read !== 1'b0) begin
            n_bad++; $display("FAIL mid_reset_halt: halt=%b read=%b expected 0 0", dma_halt, dma_read);
        end
        repeat (2) @(negedge pin_clock);
        pin_reset = 1'b0;
        par = 1'b0;
        repeat (6) tick(16'd0, 8'd0, 1'b0);
        n_cmp++;
        if (we_cnt !== 100 || dma_halt !== 1'b0) begin
            n_bad++; $display("FAIL mid_no_more_we: writes=%0d halt=%b expected 100 0", we_cnt, dma_halt);
        end
        run_dma(8'h02, 1'b0);
        n_cmp++;
        if (dlog[0] !== 16'h0200) begin
            n_bad++; $display("FAIL restart_addr: got %04h expected 0200", dlog[0]);
        end
        check_contents(8'h02, 8'h00);
    endtask

    initial begin
        test_reset();
        test_regs();
        test_dma_even();
        test_dma_odd();
        test_wrap();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/oam_dma.md
# oam_dma

Sprite-memory writer for the NES core: the opposite end of the OAM interface that the PPU reads through `ppu_cursor_oam`/`ppu_data_oam`. It decodes CPU writes to `$2003` (OAMADDR), `$2004` (OAMDATA) and `$4014` (OAM DMA). On a `$4014` write it halts the CPU and copies one 256-byte page from CPU memory into OAM. It sits between the CPU bus (`pin_address`/`pin_o`/`pin_w`), the memory read port (`pin_i`) and the OAM write port.

## Interface
Parameters:
- `DMA_REG`, `16'h4014`: DMA trigger address.
- `OAMADDR_REG`, `16'h2003`: OAM address register.
- `OAMDATA_REG`, `16'h2004`: OAM data port.

Ports:
- `pin_clock` in 1: 25 MHz system clock. Single clock domain; every flop samples on its rising edge.
- `pin_reset` in 1: asynchronous, active-high reset.
- `pin_ce` in 1: CPU cycle enable (`cpu_clock`). All state advances only on clocks where `pin_ce`=1.
- `pin_address` in 16: CPU bus address.
- `pin_o` in 8: CPU write data.
- `pin_w` in 1: CPU write strobe.
- `pin_i` in 8: memory read data, registered one `pin_clock` after the address.
- `dma_halt` out 1: stalls the CPU while DMA owns the bus.
- `dma_address` out 16: memory address while `dma_read`=1.
- `dma_read` out 1: DMA owns the memory address bus.
- `oam_address` out 8: OAM write address.
- `oam_data` out 8: OAM write data.
- `oam_we` out 1: OAM write strobe, one `pin_clock` wide.
- `oam_addr_reg` out 8: current OAMADDR value.

## Operation
- States: IDLE, HALT, ALIGN, READ, WRITE. Each transition happens on a `pin_ce` clock.
- `parity` flop: toggles on every `pin_ce`. Reset value 0.
- `$2003` write (`pin_w`, `pin_ce`, IDLE): OAMADDR ← `pin_o`.
- `$2004` write (IDLE):
  - `oam_we`=1, `oam_address`=OAMADDR, `oam_data`=`pin_o`.
  - OAMADDR ← OAMADDR+1, mod 256.
- `$4014` write (IDLE):
  - Latch `page` ← `pin_o`, clear index `i` ← 0.
  - Next state HALT.
- HALT: one dummy cycle. Next state is ALIGN if `parity`=1 at this cycle, otherwise READ.
- ALIGN: one dummy cycle, then READ.
- READ:
  - `dma_read`=1, `dma_address`={`page`,`i`}.
  - Next state WRITE.
- WRITE:
  - `oam_we`=1 on the `pin_ce` clock.
  - `oam_address`=OAMADDR+`i` (8-bit wrap).
  - `oam_data`=`pin_i`.
  - `i` ← `i`+1.
  - If `i`=255, next state is IDLE; otherwise READ.
- `dma_halt`=1 in HALT, ALIGN, READ and WRITE.
- OAMADDR is unchanged after DMA; the 256 writes wrap back to the start offset.
- Register writes while not in IDLE are ignored. The CPU is halted then, so such writes are bus noise.
- Non-`pin_ce` clocks: all state and outputs hold, and `oam_we`=0.

## Timing
- Reset values: state IDLE; `dma_halt`, `dma_read`, `oam_we` = 0; `dma_address`, `oam_address`, `oam_data`, `oam_addr_reg` = 0; `page`, `i`, `parity` = 0.
- Reset asserted mid-DMA: immediate return to IDLE with outputs at reset values. A partial copy is left in OAM.
- `dma_halt` rises on the `pin_clock` edge that samples the `$4014` write.
- DMA length:
  - 513 `pin_ce` cycles: 1 HALT + 512 READ/WRITE.
  - 514 `pin_ce` cycles when ALIGN is taken.
- `dma_halt` falls on the edge that completes the final WRITE.
- Read data latency:
  - `pin_i` is valid one `pin_clock` after `dma_address`.
  - `pin_ce` spacing is at least 2 clocks, so `pin_i` is stable by the WRITE `pin_ce` clock.
- `$2004`: `oam_we` occurs on the same `pin_ce` clock as the CPU write. `oam_addr_reg` shows the increment on the following clock.
- A `$4014` write and a `$2004` write cannot coincide; address decode is exclusive.

## Test plan
- **Reset:** assert `pin_reset` asynchronously between clock edges → all outputs 0 immediately, `oam_addr_reg`=0.
- **Register writes:** `$2003`←`8'h10`, then `$2004`←`8'hAA`, then `$2004`←`8'hBB` → OAM[`8'h10`]=`8'hAA`, OAM[`8'h11`]=`8'hBB`, `oam_addr_reg`=`8'h12`.
- **Even-parity DMA:** `$4014`←`8'h02` with `parity`=0, memory `$0200`+n = n ^ `8'h5A`, OAMADDR=0 → `dma_halt` high for exactly 513 `pin_ce` cycles, OAM[n] = n ^ `8'h5A` for all 256 n.
- **Odd-parity DMA:** same transfer with `parity`=1 → 514 cycles, identical OAM contents, `dma_address` sequence `$0200`..`$02FF`.
- **Wrapped offset:** OAMADDR=`8'hF0` before DMA of page `8'h03` → source `$0300` lands in OAM[`8'hF0`], source `$0310` lands in OAM[`8'h00`], `oam_addr_reg` still `8'hF0` after DMA.
- **Reset mid-DMA:** pulse `pin_reset` after 100 writes → `dma_halt`=0 at once, no further `oam_we`, a new `$4014` write restarts from `i`=0.
